// File: rtl/lap_stash.sv
// lap_stash: circular history of the last DEPTH captured samples (e.g. lap
// times). A capture jumps the display to the newest entry; the user can
// browse forwards/backwards over the entries that were actually written.
// OVERWRITE selects between dropping the oldest entry or rejecting new
// samples once the buffer is full. Pointer arithmetic is done modulo DEPTH,
// so DEPTH does not have to be a power of two.
module lap_stash #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int OVERWRITE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           sample_in,
    input  logic                       sample_in_valid,
    input  logic                       next_sample,
    input  logic                       prev_sample,
    output logic [WIDTH-1:0]           sample_out,
    output logic [$clog2(DEPTH)-1:0]   index_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);      // physical / logical position width
    localparam int CW = $clog2(DEPTH+1);    // occupancy width (0..DEPTH)
    localparam int EW = CW + 1;             // headroom for un-wrapped sums

    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [AW-1:0] pos_reg,    pos_next;
    logic          dropped_reg, dropped_next;

    logic          is_full;
    logic          capture_ok;
    logic [AW-1:0] last_pos;
    logic [EW-1:0] wr_ext, cnt_ext, pos_ext;
    logic [EW-1:0] oldest_ext, addr_sum, rd_addr_ext;
    logic [AW-1:0] rd_addr;

    assign is_full    = (count_reg == DEPTH_C);
    assign capture_ok = sample_in_valid && (!is_full || (OVERWRITE != 0));
    // Newest logical position; only meaningful when count_reg > 0.
    assign last_pos   = AW'(count_reg - CW'(1));

    // Map logical display position to a physical slot: (wr_ptr - count + pos) mod DEPTH.
    always_comb begin
        wr_ext      = EW'(wr_ptr_reg);
        cnt_ext     = EW'(count_reg);
        pos_ext     = EW'(pos_reg);
        oldest_ext  = (wr_ext >= cnt_ext) ? (wr_ext - cnt_ext)
                                          : (wr_ext + DEPTH_E - cnt_ext);
        addr_sum    = oldest_ext + pos_ext;
        rd_addr_ext = (addr_sum >= DEPTH_E) ? (addr_sum - DEPTH_E) : addr_sum;
        rd_addr     = rd_addr_ext[AW-1:0];
    end

    // Next-state: clear beats capture, capture (accepted or rejected) beats browse.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        pos_next     = pos_reg;
        dropped_next = 1'b0;
        if (clear) begin
            wr_ptr_next = '0;
            count_next  = '0;
            pos_next    = '0;
        end else if (sample_in_valid) begin
            if (capture_ok) begin
                wr_ptr_next = (wr_ptr_reg == LAST_A) ? '0 : wr_ptr_reg + AW'(1);
                if (is_full) begin
                    // Oldest entry is overwritten; occupancy stays at DEPTH.
                    count_next = count_reg;
                    pos_next   = LAST_A;
                end else begin
                    count_next = count_reg + CW'(1);
                    pos_next   = AW'(count_reg);
                end
            end else begin
                dropped_next = 1'b1;
            end
        end else if ((count_reg != '0) && (next_sample != prev_sample)) begin
            if (next_sample) begin
                pos_next = (pos_reg == last_pos) ? '0 : pos_reg + AW'(1);
            end else begin
                pos_next = (pos_reg == '0) ? last_pos : pos_reg - AW'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            pos_reg     <= '0;
            dropped_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            pos_reg     <= pos_next;
            dropped_reg <= dropped_next;
        end
    end

    // Sample storage; contents are never cleared, occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && !clear && capture_ok) begin
            mem[wr_ptr_reg] <= sample_in;
        end
    end

    assign sample_out = (count_reg == '0) ? '0 : mem[rd_addr];
    assign index_out  = pos_reg;
    assign count_out  = count_reg;
    assign full       = is_full;
    assign empty      = (count_reg == '0);
    assign dropped    = dropped_reg;

endmodule

// File: doc/lap_stash.md
Name: lap_stash

Overview:
- Parametrised successor to the 8-bit sample stash.
- A circular history buffer of the last DEPTH captured values, such as stopwatch lap times.
- Displays the newest value on capture. The user browses stored entries forwards and backwards, and only over entries actually written.
- Adds a selectable overwrite/stop-when-full mode, a synchronous clear, and occupancy, position and drop status outputs.
- Sits between the time counter/capture logic and the display mux.

Parameters:
WIDTH, 8, bit width of each stored sample.
DEPTH, 5, number of entries; legal range 2..256.
OVERWRITE, 1, 1 = overwrite the oldest entry when full; 0 = drop new samples when full.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous clear of all history.
sample_in  input  WIDTH  value to capture.
sample_in_valid  input  1  capture strobe; one capture per cycle asserted.
next_sample  input  1  browse one entry forward (toward newer, wrapping newest->oldest); one step per cycle asserted.
prev_sample  input  1  browse one entry backward (toward older, wrapping oldest->newest); one step per cycle asserted.
sample_out  output  WIDTH  entry currently displayed; 0 when empty.
index_out  output  $clog2(DEPTH)  logical position of displayed entry; 0 = oldest, count_out-1 = newest.
count_out  output  $clog2(DEPTH+1)  number of valid entries.
full  output  1  count_out == DEPTH.
empty  output  1  count_out == 0.
dropped  output  1  one-cycle pulse: a capture was rejected because the buffer was full and OVERWRITE=0.

Behaviour:
- State: mem[DEPTH], wr_ptr (physical slot of the next write), count, pos (logical display position).
  - oldest = (wr_ptr - count) mod DEPTH.
  - Displayed physical address = (oldest + pos) mod DEPTH.
  - All pointer arithmetic is explicit modulo DEPTH; DEPTH need not be a power of 2.
- Reset (async, any time, including mid-browse):
  - wr_ptr=0, count=0, pos=0, dropped=0; memory contents need not be cleared.
  - Outputs update immediately, without waiting for a clock edge: sample_out=0, index_out=0, count_out=0, empty=1, full=0.
- Output timing: sample_out, index_out, count_out, full and empty are combinational from registered state. They reflect an operation right after the capturing edge, so latency is one edge.
- Per-cycle priority: reset > clear > capture > browse.
- Clear: count=0, pos=0, wr_ptr=0, dropped=0; any same-cycle capture or browse is ignored.
- Capture accepted when sample_in_valid=1 and (count<DEPTH or OVERWRITE=1):
  - mem[wr_ptr]<=sample_in; wr_ptr<=wr_ptr+1 mod DEPTH; count<=min(count+1, DEPTH).
  - pos<=new count-1, i.e. display jumps to the newest entry.
  - When full with OVERWRITE=1, the oldest entry is lost and count stays DEPTH.
- Capture rejected when sample_in_valid=1, count==DEPTH and OVERWRITE=0:
  - No state change; dropped=1 for exactly that cycle.
- Browse: applies only when no capture/clear occurs in that cycle and count>0.
  - next_sample alone: pos<=(pos==count-1) ? 0 : pos+1.
  - prev_sample alone: pos<=(pos==0) ? count-1 : pos-1.
  - next_sample and prev_sample together: no change.
  - Browse while empty: no change.
- Capture and browse in the same cycle: capture wins; the browse is discarded, not deferred. A rejected capture (dropped) also discards the browse.
- With count==1, browsing leaves pos=0.
- dropped is registered; it is 0 in every cycle without a rejected capture.

Test Plan:
- Reset: assert reset between edges -> immediately sample_out=0, count_out=0, empty=1, full=0, index_out=0, dropped=0.
- DEPTH=5, OVERWRITE=1, capture 0..6 one per two cycles -> after each capture sample_out equals the captured value. Final state: count_out=5, full=1, index_out=4, sample_out=6. Then next_sample x5 -> 2,3,4,5,6.
- Partial fill:
  - After clear, capture 10,11,12 -> count_out=3, sample_out=12.
  - next -> 10 (index 0), next -> 11.
  - prev -> 10, prev -> 12 (wrap to index 2).
  - next+prev same cycle -> unchanged.
- OVERWRITE=0, DEPTH=5:
  - Capture 0..4 -> full=1.
  - Capture 9 -> dropped=1 for one cycle; sample_out=4, count_out=5 unchanged.
  - Browse -> only 0..4 seen.
- Collisions:
  - Capture 7 with next_sample high in the same cycle -> sample_out=7, index_out=count_out-1.
  - clear with sample_in_valid high in the same cycle -> empty=1, sample_out=0, count_out=0.
- Reset mid-browse after several captures -> all outputs 0/empty. Then capture 3 -> sample_out=3, count_out=1, and next/prev leave sample_out=3.
